// File: rtl/qtt_result_buffer_if.sv
// rtl/qtt_result_buffer_if.sv - candidate word input and byte stream output bundle
interface qtt_result_buffer_if #(
    parameter int WORD_SIZE = 256
);
    logic [WORD_SIZE-1:0] word_in;
    logic                 word_valid;
    logic                 v1_valid;
    logic                 vcs_valid;
    logic                 l0_valid;
    logic                 l1_valid;
    logic [7:0]           m_data;
    logic                 m_valid;
    logic                 m_ready;
    logic                 m_last;

    modport slave (
        input  word_in, word_valid, v1_valid, vcs_valid, l0_valid, l1_valid, m_ready,
        output m_data, m_valid, m_last
    );

    modport master (
        output word_in, word_valid, v1_valid, vcs_valid, l0_valid, l1_valid, m_ready,
        input  m_data, m_valid, m_last
    );
endinterface

// File: rtl/qtt_result_buffer.sv
// rtl/qtt_result_buffer.sv - buffers words passing all criteria and streams them out bytewise
module qtt_result_buffer #(
    parameter int WORD_SIZE  = 256,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    qtt_result_buffer_if.slave            bus,
    output logic [CNT_WIDTH-1:0]          words_total,
    output logic [CNT_WIDTH-1:0]          words_found,
    output logic [15:0]                   words_dropped,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int NBYTES = WORD_SIZE / 8;
    localparam int IDX_W  = $clog2(NBYTES);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [WORD_SIZE-1:0] sr_q, sr_d;
    logic [WORD_SIZE-1:0] mem_q [FIFO_DEPTH];
    logic [WORD_SIZE-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic [CNT_WIDTH-1:0] total_q, total_d;
    logic [CNT_WIDTH-1:0] found_q, found_d;
    logic [15:0]          dropped_q, dropped_d;

    logic found, is_last, accept, empty, pop, push, drop;

    always_comb begin
        found   = bus.word_valid & bus.v1_valid & bus.vcs_valid & bus.l0_valid & bus.l1_valid;
        is_last = (state_q == ST_SEND) && (idx_q == LAST_IDX);
        accept  = (state_q == ST_SEND) && bus.m_ready;
        empty   = (level_q == '0);
        // A pop either starts a word from idle or chains straight after the final byte.
        pop     = !empty && ((state_q == ST_IDLE) || (accept && is_last));
        push    = found && ((level_q != FULL_LVL) || pop);
        drop    = found && !push;

        state_d = state_q;
        idx_d   = idx_q;
        sr_d    = sr_q;
        if (pop) begin
            sr_d    = mem_q[rd_ptr_q];
            idx_d   = '0;
            state_d = ST_SEND;
        end else if (accept) begin
            if (is_last) begin
                sr_d    = '0;
                idx_d   = '0;
                state_d = ST_IDLE;
            end else begin
                sr_d  = sr_q >> 8;
                idx_d = idx_q + IDX_W'(1);
            end
        end

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = bus.word_in;
        end
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        total_d   = (bus.word_valid && (total_q != '1)) ? total_q + CNT_WIDTH'(1) : total_q;
        found_d   = (found && (found_q != '1)) ? found_q + CNT_WIDTH'(1) : found_q;
        dropped_d = (drop && (dropped_q != '1)) ? dropped_q + 16'd1 : dropped_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            sr_q      <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            total_q   <= '0;
            found_q   <= '0;
            dropped_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            sr_q      <= sr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            total_q   <= total_d;
            found_q   <= found_d;
            dropped_q <= dropped_d;
        end
    end

    // Storage needs no reset; occupancy is tracked entirely by the pointers and level.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.m_valid    = (state_q == ST_SEND);
    assign bus.m_data     = sr_q[7:0];
    assign bus.m_last     = is_last;
    assign words_total    = total_q;
    assign words_found    = found_q;
    assign words_dropped  = dropped_q;
    assign fifo_level     = level_q;
endmodule
